// File: rtl/apb_arbiter_2to1.sv
// Round-robin 2:1 APB arbiter: two requester ports share one completer-facing port, one transfer in flight.
// Optional macro APB_PSLVERR_EN routes completer PSLVERR back to the granted requester.

module apb_arbiter_2to1 #(
  parameter int unsigned G_REGWIDTH   = 32,
  parameter int unsigned G_ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s0_apb_psel,
  input  logic                      s0_apb_penable,
  input  logic                      s0_apb_pwrite,
  input  logic [2:0]                s0_apb_pprot,
  input  logic [G_ADDR_WIDTH-1:0]   s0_apb_paddr,
  input  logic [G_REGWIDTH-1:0]     s0_apb_pwdata,
  input  logic [G_REGWIDTH/8-1:0]   s0_apb_pstrb,
  output logic                      s0_apb_pready,
  output logic [G_REGWIDTH-1:0]     s0_apb_prdata,
  input  logic                      s1_apb_psel,
  input  logic                      s1_apb_penable,
  input  logic                      s1_apb_pwrite,
  input  logic [2:0]                s1_apb_pprot,
  input  logic [G_ADDR_WIDTH-1:0]   s1_apb_paddr,
  input  logic [G_REGWIDTH-1:0]     s1_apb_pwdata,
  input  logic [G_REGWIDTH/8-1:0]   s1_apb_pstrb,
  output logic                      s1_apb_pready,
  output logic [G_REGWIDTH-1:0]     s1_apb_prdata,
`ifdef APB_PSLVERR_EN
  input  logic                      m_apb_pslverr,
  output logic                      s0_apb_pslverr,
  output logic                      s1_apb_pslverr,
`endif
  output logic                      m_apb_psel,
  output logic                      m_apb_penable,
  output logic                      m_apb_pwrite,
  output logic [2:0]                m_apb_pprot,
  output logic [G_ADDR_WIDTH-1:0]   m_apb_paddr,
  output logic [G_REGWIDTH-1:0]     m_apb_pwdata,
  output logic [G_REGWIDTH/8-1:0]   m_apb_pstrb,
  input  logic                      m_apb_pready,
  input  logic [G_REGWIDTH-1:0]     m_apb_prdata,
  output logic                      arb_grant,
  output logic                      arb_busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e r_state;
  state_e w_next_state;
  logic   r_grant;
  logic   r_last_grant;
  logic   w_any_req;
  logic   w_pick;
  logic   w_done;
  logic   w_unused_penable;

  // PENABLE from requesters is protocol framing only; arbitration keys off PSEL.
  assign w_unused_penable = s0_apb_penable | s1_apb_penable;

  assign w_any_req = s0_apb_psel | s1_apb_psel;
  assign w_pick    = (s0_apb_psel && s1_apb_psel) ? ~r_last_grant : s1_apb_psel;
  assign w_done    = (r_state == ST_ACCESS) && m_apb_pready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      if ((r_state == ST_IDLE) && w_any_req) begin
        r_grant <= w_pick;
      end
      if (w_done) begin
        r_last_grant <= r_grant;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (w_any_req) w_next_state = ST_SETUP;
      ST_SETUP:  w_next_state = ST_ACCESS;
      ST_ACCESS: if (m_apb_pready) w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    m_apb_psel     = 1'b0;
    m_apb_penable  = 1'b0;
    m_apb_pwrite   = 1'b0;
    m_apb_pprot    = 3'd0;
    m_apb_paddr    = '0;
    m_apb_pwdata   = '0;
    m_apb_pstrb    = '0;
    s0_apb_pready  = 1'b0;
    s0_apb_prdata  = '0;
    s1_apb_pready  = 1'b0;
    s1_apb_prdata  = '0;
`ifdef APB_PSLVERR_EN
    s0_apb_pslverr = 1'b0;
    s1_apb_pslverr = 1'b0;
`endif
    arb_grant      = r_grant;
    arb_busy       = (r_state != ST_IDLE);
    if (r_state != ST_IDLE) begin
      m_apb_psel   = 1'b1;
      m_apb_pwrite = r_grant ? s1_apb_pwrite : s0_apb_pwrite;
      m_apb_pprot  = r_grant ? s1_apb_pprot  : s0_apb_pprot;
      m_apb_paddr  = r_grant ? s1_apb_paddr  : s0_apb_paddr;
      m_apb_pwdata = r_grant ? s1_apb_pwdata : s0_apb_pwdata;
      m_apb_pstrb  = r_grant ? s1_apb_pstrb  : s0_apb_pstrb;
    end
    if (r_state == ST_ACCESS) begin
      m_apb_penable = 1'b1;
    end
    // Completion is steered to the granted requester only.
    if (w_done) begin
      if (r_grant) begin
        s1_apb_pready  = 1'b1;
        s1_apb_prdata  = m_apb_prdata;
`ifdef APB_PSLVERR_EN
        s1_apb_pslverr = m_apb_pslverr;
`endif
      end else begin
        s0_apb_pready  = 1'b1;
        s0_apb_prdata  = m_apb_prdata;
`ifdef APB_PSLVERR_EN
        s0_apb_pslverr = m_apb_pslverr;
`endif
      end
    end
  end

endmodule

// File: doc/apb_arbiter_2to1.md
Name: apb_arbiter_2to1

Overview:
- Two-requester APB arbiter: shares one APB completer-facing master port (m_apb_*) between two APB requester ports (s0_apb_*, s1_apb_*).
- Round-robin grant; one transfer in flight at a time.
- Regenerates APB SETUP/ACCESS phases on the master side and returns PREADY/PRDATA to the granted requester only.
- Sits between bus masters (CPU bridge, DMA) and a shared APB register block.

Parameters:
G_REGWIDTH, 32, data width of PWDATA/PRDATA; must be a multiple of 8
G_ADDR_WIDTH, 32, address width of PADDR

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
s0_apb_psel  input  1  requester 0 select
s0_apb_penable  input  1  requester 0 enable; protocol only, not used for arbitration
s0_apb_pwrite  input  1  requester 0 write
s0_apb_pprot  input  3  requester 0 protection
s0_apb_paddr  input  G_ADDR_WIDTH  requester 0 address
s0_apb_pwdata  input  G_REGWIDTH  requester 0 write data
s0_apb_pstrb  input  G_REGWIDTH/8  requester 0 strobes
s0_apb_pready  output  1  requester 0 transfer complete
s0_apb_prdata  output  G_REGWIDTH  requester 0 read data
s1_apb_*  same set as s0, for requester 1
m_apb_psel, m_apb_penable, m_apb_pwrite  output  1 each  shared master control
m_apb_pprot  output  3  shared master protection
m_apb_paddr  output  G_ADDR_WIDTH  shared master address
m_apb_pwdata  output  G_REGWIDTH  shared master write data
m_apb_pstrb  output  G_REGWIDTH/8  shared master strobes
m_apb_pready  input  1  completer ready
m_apb_prdata  input  G_REGWIDTH  completer read data
arb_grant  output  1  index of current/last granted requester
arb_busy  output  1  high in SETUP and ACCESS

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values: state=IDLE, arb_grant=0, last_grant=1 (so s0 wins the first tie), arb_busy=0, m_apb_psel=0, m_apb_penable=0, all m_apb data/address/control outputs 0, sN_apb_pready=0, sN_apb_prdata=0.
- FSM IDLE:
  - If any sN_apb_psel=1, register the grant and go to SETUP.
  - Only one requesting: grant it.
  - Both requesting: grant the index != last_grant.
  - Otherwise stay in IDLE.
- FSM SETUP: m_apb_psel=1, m_apb_penable=0; unconditionally go to ACCESS.
- FSM ACCESS:
  - m_apb_psel=1, m_apb_penable=1.
  - When m_apb_pready=1, set last_grant=grant and go to IDLE.
  - Otherwise hold with unlimited wait states.
- Master-side outputs: m_apb pwrite/pprot/paddr/pwdata/pstrb are muxed combinationally from the granted requester while in SETUP or ACCESS, and are 0 in IDLE. Requesters hold these stable until their PREADY, per APB.
- Requester handshake:
  - sN_apb_pready = (state==ACCESS) && (grant==N) && m_apb_pready, combinational.
  - sN_apb_prdata = m_apb_prdata under the same qualifier, else 0.
  - The non-granted requester sees pready=0 and keeps waiting.
- Latency: psel asserted in cycle 0 gives master SETUP in cycle 1, ACCESS in cycle 2, and the earliest requester pready in cycle 2. Each wait state adds 1 cycle.
- Back-to-back: after completion the FSM returns to IDLE for one cycle. A requester holding psel=1 for a new transfer, or the other waiting requester, is granted there. Peak master throughput is 1 transfer per 3 cycles.
- Fairness: with both continuously requesting, grants strictly alternate 0,1,0,1.
- A requester deasserting psel before its grant is a protocol violation; behaviour is undefined and need not be checked.
- arb_grant holds its value in IDLE.
- Reset mid-transfer: at the next edge with rst=1, go to IDLE and drop m_apb_psel/penable. The in-flight transfer is abandoned with no pready to either requester, and last_grant returns to 1.

Optional Feature:
- Macro APB_PSLVERR_EN.
- When defined:
  - Adds input m_apb_pslverr and outputs s0_apb_pslverr and s1_apb_pslverr.
  - sN_apb_pslverr = m_apb_pslverr under the same qualifier as sN_apb_pready, else 0.
  - These ports reset to 0.
- When undefined: these ports do not exist and errors are not reported. Arbitration and timing are identical in both builds.

Test Plan:
- Single write: s0 write paddr=0x10, pwdata=0xDEADBEEF, pstrb=0xF, m_apb_pready tied 1 -> m_apb_psel high cycles 1-2, penable cycle 2, m_apb_paddr=0x10, s0_apb_pready=1 in cycle 2 only, s1_apb_pready=0 throughout.
- Wait states: s1 read of 0x24, completer holds pready=0 for 3 ACCESS cycles then returns prdata=0x12345678 -> s1_apb_pready pulses once with s1_apb_prdata=0x12345678, arb_grant=1.
- Tie after reset: both psel in the same cycle (s0 write 0x100, s1 write 0x200) -> s0 is served first (m_apb_paddr=0x100), then s1 (0x200); s1's pready stays 0 until its own ACCESS.
- Fairness: both requesters issue 4 back-to-back transfers each -> master address order alternates s0,s1,s0,s1,..., and every transfer occupies exactly 3 cycles with pready=1.
- Reset mid-ACCESS: rst=1 for one cycle while ACCESS is waiting with pready=0 -> the next cycle has m_apb_psel=0, m_apb_penable=0, no requester pready, and arb_busy=0. A subsequent tie grants s0.
- With APB_PSLVERR_EN: completer returns pslverr=1 with pready on an s0 read -> s0_apb_pslverr=1 for that cycle only, s1_apb_pslverr=0.
